// File: rtl/oldest_select_pipe.sv
// Pipelined oldest-ready-entry selector: input capture stage, combinational
// wrap-safe age reduction, result stage, valid/ready handshake on both sides.
module oldest_select_pipe #(
    parameter int unsigned ENTNUM = 8,
    parameter int unsigned ENTLEN = 3,
    parameter int unsigned VALLEN = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       flush_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [VALLEN-1:0]          head_i,
    input  logic [ENTNUM-1:0]          ready_vector_i,
    input  logic [ENTNUM*ENTLEN-1:0]   entry_vector_i,
    input  logic [ENTNUM*VALLEN-1:0]   value_vector_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic                       found_o,
    output logic [ENTLEN-1:0]          oldest_entry_o,
    output logic [VALLEN-1:0]          oldest_value_o,
    output logic [$clog2(ENTNUM)-1:0]  oldest_index_o
);

    localparam int unsigned IDXLEN = $clog2(ENTNUM);
    localparam int unsigned KEYLEN = VALLEN + 1;

    if (ENTNUM < 2 || (ENTNUM & (ENTNUM - 1)) != 0) begin : g_bad_entnum
        $error("oldest_select_pipe: ENTNUM must be a power of two >= 2");
    end

    // Stage A: captured request
    logic                      r_a_valid;
    logic [VALLEN-1:0]         r_a_head;
    logic [ENTNUM-1:0]         r_a_ready;
    logic [ENTNUM*ENTLEN-1:0]  r_a_entry;
    logic [ENTNUM*VALLEN-1:0]  r_a_value;

    // Stage B: result
    logic                      r_b_valid;
    logic                      r_b_found;
    logic [ENTLEN-1:0]         r_b_entry;
    logic [VALLEN-1:0]         r_b_value;
    logic [IDXLEN-1:0]         r_b_index;

    logic                      w_b_en;
    logic                      w_a_en;
    logic                      w_a_load;
    logic                      w_found;
    logic [KEYLEN-1:0]         w_key;
    logic [KEYLEN-1:0]         w_best_key;
    logic [IDXLEN-1:0]         w_best_idx;
    logic [ENTLEN-1:0]         w_best_entry;
    logic [VALLEN-1:0]         w_best_value;

    assign w_b_en      = !r_b_valid | rsp_ready_i;
    assign w_a_en      = !r_a_valid | w_b_en;
    assign req_ready_o = w_a_en & !flush_i;
    assign w_a_load    = req_valid_i & req_ready_o;
    assign w_found     = |r_a_ready;

    // Key = {not ready, head-relative age}; strict compare keeps lowest slot on ties
    always_comb begin
        w_key        = '0;
        w_best_key   = '1;
        w_best_idx   = '0;
        w_best_entry = '0;
        w_best_value = '0;
        for (int k = 0; k < int'(ENTNUM); k++) begin
            w_key = {~r_a_ready[k], VALLEN'(r_a_value[k*VALLEN +: VALLEN] - r_a_head)};
            if (k == 0 || w_key < w_best_key) begin
                w_best_key   = w_key;
                w_best_idx   = IDXLEN'(k);
                w_best_entry = r_a_entry[k*ENTLEN +: ENTLEN];
                w_best_value = r_a_value[k*VALLEN +: VALLEN];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_a_valid <= 1'b0;
            r_a_head  <= '0;
            r_a_ready <= '0;
            r_a_entry <= '0;
            r_a_value <= '0;
        end else begin
            if (flush_i) begin
                r_a_valid <= 1'b0;
            end else if (w_a_en) begin
                r_a_valid <= w_a_load;
            end
            if (w_a_load) begin
                r_a_head  <= head_i;
                r_a_ready <= ready_vector_i;
                r_a_entry <= entry_vector_i;
                r_a_value <= value_vector_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_b_valid <= 1'b0;
            r_b_found <= 1'b0;
            r_b_entry <= '0;
            r_b_value <= '0;
            r_b_index <= '0;
        end else begin
            if (flush_i) begin
                r_b_valid <= 1'b0;
            end else if (w_b_en) begin
                r_b_valid <= r_a_valid;
            end
            if (w_b_en) begin
                r_b_found <= w_found;
                r_b_entry <= w_found ? w_best_entry : '0;
                r_b_value <= w_found ? w_best_value : '0;
                r_b_index <= w_found ? w_best_idx   : '0;
            end
        end
    end

    assign rsp_valid_o    = r_b_valid;
    assign found_o        = r_b_found;
    assign oldest_entry_o = r_b_entry;
    assign oldest_value_o = r_b_value;
    assign oldest_index_o = r_b_index;

endmodule

// File: tb/tb_oldest_select_pipe.sv
// Bench for oldest_select_pipe: directed scenarios plus random traffic checked
// against a queue-based transaction model of the selector.
module tb_oldest_select_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  head;
    logic [7:0]  ready_vec;
    logic [23:0] entry_vec;
    logic [63:0] value_vec;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        found;
    logic [2:0]  o_entry;
    logic [7:0]  o_value;
    logic [2:0]  o_index;

    always #5 clk = ~clk;

    oldest_select_pipe #(.ENTNUM(8), .ENTLEN(3), .VALLEN(8)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .flush_i        (flush),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .head_i         (head),
        .ready_vector_i (ready_vec),
        .entry_vector_i (entry_vec),
        .value_vector_i (value_vec),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .found_o        (found),
        .oldest_entry_o (o_entry),
        .oldest_value_o (o_value),
        .oldest_index_o (o_index)
    );

    typedef struct {
        logic       found;
        logic [2:0] entry;
        logic [7:0] value;
        logic [2:0] index;
        int         t;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   edge_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Among eligible slots, the smallest (value - head) mod 256; first such slot wins
    function automatic exp_t model(input logic [7:0] h, input logic [7:0] rdy,
                                   input logic [23:0] ents, input logic [63:0] vals);
        exp_t r;
        int   best;
        int   best_age;
        int   age;
        r.found = 1'b0; r.entry = '0; r.value = '0; r.index = '0; r.t = 0;
        best = -1;
        best_age = 0;
        for (int k = 0; k < 8; k++) begin
            if (rdy[k]) begin
                age = (int'(vals[k*8 +: 8]) - int'(h) + 256) % 256;
                if (best < 0 || age < best_age) begin
                    best = k;
                    best_age = age;
                end
            end
        end
        if (best >= 0) begin
            r.found = 1'b1;
            r.index = 3'(best);
            r.entry = ents[best*3 +: 3];
            r.value = vals[best*8 +: 8];
        end
        return r;
    endfunction

    task automatic set_req(input logic [7:0] h, input logic [7:0] rdy, input logic [63:0] vals);
        head      = h;
        ready_vec = rdy;
        value_vec = vals;
        for (int k = 0; k < 8; k++) entry_vec[k*3 +: 3] = 3'(k);
    endtask

    task automatic set_rand_req();
        logic [7:0] h;
        h = 8'($urandom);
        head      = h;
        ready_vec = 8'($urandom);
        entry_vec = 24'($urandom);
        for (int k = 0; k < 8; k++)
            value_vec[k*8 +: 8] = ($urandom_range(0, 2) == 0) ? 8'(h + 8'($urandom_range(0, 3)))
                                                              : 8'($urandom);
    endtask

    // One clock: check outputs against the model, advance, update the model
    task automatic cyc(output bit acc);
        exp_t e;
        bit   exp_v;
        bit   pop;
        #1;
        exp_v = (q.size() > 0) && (edge_cnt > q[0].t);
        check("rsp_valid", 32'(rsp_valid), 32'(exp_v));
        check("req_ready", 32'(req_ready), 32'(!flush && (q.size() < 2 || rsp_ready)));
        if (exp_v) begin
            check("found", 32'(found),   32'(q[0].found));
            check("entry", 32'(o_entry), 32'(q[0].entry));
            check("value", 32'(o_value), 32'(q[0].value));
            check("index", 32'(o_index), 32'(q[0].index));
        end
        pop = exp_v && rsp_ready;
        acc = req_valid && !flush && (q.size() < 2 || rsp_ready);
        e = model(head, ready_vec, entry_vec, value_vec);
        @(posedge clk);
        edge_cnt++;
        if (pop) void'(q.pop_front());
        if (flush) q.delete();
        if (acc) begin
            e.t = edge_cnt;
            q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic spot(input string tag, input logic f, input logic [2:0] idx, input logic [7:0] val);
        #1;
        check({tag, "_valid"}, 32'(rsp_valid), 32'(1));
        check({tag, "_found"}, 32'(found),     32'(f));
        check({tag, "_index"}, 32'(o_index),   32'(idx));
        check({tag, "_entry"}, 32'(o_entry),   32'(idx));
        check({tag, "_value"}, 32'(o_value),   32'(val));
    endtask

    initial begin
        bit         acc;
        int         n;
        logic [63:0] v;
        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        set_req(8'h00, 8'h00, 64'h0);
        repeat (3) @(negedge clk);
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_found",     32'(found),     32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Tie, wrap, mask and empty cases back to back
        req_valid = 1'b1;
        set_req(8'h00, 8'hFF, {8'h40, 8'h40, 8'h40, 8'h40, 8'h03, 8'h07, 8'h03, 8'h09});
        cyc(acc);
        set_req(8'hF0, 8'h24, {16'h0, 8'hF8, 16'h0, 8'h05, 16'h0});
        cyc(acc);
        spot("basic", 1'b1, 3'd1, 8'h03);
        set_req(8'h00, 8'h10, {24'h0, 8'hFF, 32'h0});
        cyc(acc);
        spot("wrap", 1'b1, 3'd5, 8'hF8);
        set_req(8'h00, 8'h00, 64'h0123_4567_89AB_CDEF);
        cyc(acc);
        spot("mask", 1'b1, 3'd4, 8'hFF);
        req_valid = 1'b0;
        cyc(acc);
        spot("empty", 1'b0, 3'd0, 8'h00);
        repeat (2) cyc(acc);

        // Backpressure: consumer stalls for the first three cycles
        n = 0;
        set_rand_req();
        req_valid = 1'b1;
        for (int c = 0; c < 30 && n < 4; c++) begin
            rsp_ready = (c >= 3);
            cyc(acc);
            if (acc) begin
                n++;
                set_rand_req();
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        check("bp_accepted", 32'(n), 32'(4));
        repeat (4) cyc(acc);

        // Flush with both stages full and a request offered
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        repeat (2) begin set_rand_req(); cyc(acc); end
        flush = 1'b1;
        set_req(8'h00, 8'h01, 64'h0);
        cyc(acc);
        flush = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) cyc(acc);

        // Asynchronous reset with both stages full
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        repeat (2) begin set_rand_req(); cyc(acc); end
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("midrst_found",     32'(found),     32'(0));
        check("midrst_entry",     32'(o_entry),   32'(0));
        check("midrst_value",     32'(o_value),   32'(0));
        check("midrst_index",     32'(o_index),   32'(0));
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        repeat (3) cyc(acc);

        // Random traffic with occasional stalls and flushes
        for (int i = 0; i < 400; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            set_rand_req();
            cyc(acc);
        end
        flush = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (4) cyc(acc);
        v = 64'h0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
